// File: rtl/painterengine_gpu_dma_writer_pkg.sv
// painterengine_gpu_dma_writer_pkg: FSM state codes, error-type codes and AXI constants shared by the GPU DMA writer.
package painterengine_gpu_dma_writer_pkg;
  typedef enum logic [2:0] {
    ST_ROUTING, ST_PARAM_CHECK, ST_CALC, ST_ADDR, ST_DATA, ST_RESP, ST_DONE, ST_ERROR
  } state_e;
  typedef enum logic [2:0] {
    ERR_NONE, ERR_ROUTER, ERR_ADDRESS, ERR_ADDR_TIMEOUT, ERR_DATA_TIMEOUT, ERR_BRESP
  } err_e;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_MOD  = 4'b0010;
  function automatic logic [1:0] router_index(input logic [3:0] r);
    return r[3] ? 2'd3 : r[2] ? 2'd2 : r[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/painterengine_gpu_dma_source_mux.sv
// painterengine_gpu_dma_source_mux: 4:1 select of source data/valid and fan-out of the pop strobe.
//   i_data/i_valid : four 32b sources and their valids
//   i_idx          : selected source
//   i_next         : pop request for the selected source
//   o_data/o_valid : selected word and valid
//   o_next         : per-source pop, only bit i_idx can be set
module painterengine_gpu_dma_source_mux (
  input  logic [127:0] i_data,
  input  logic [3:0]   i_valid,
  input  logic [1:0]   i_idx,
  input  logic         i_next,
  output logic [31:0]  o_data,
  output logic         o_valid,
  output logic [3:0]   o_next
);
  always_comb begin
    o_data  = i_data[{i_idx, 5'd0} +: 32];
    o_valid = i_valid[i_idx];
    o_next  = {3'b000, i_next} << i_idx;
  end
endmodule

// File: rtl/painterengine_gpu_dma_writer.sv
// painterengine_gpu_dma_writer: AXI4 write master draining one of four word streams into memory as INCR bursts.
module painterengine_gpu_dma_writer
  import painterengine_gpu_dma_writer_pkg::*;
#(
  parameter int TIMEOUT_BIT = 18,
  parameter int MAX_BURST = 256
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_resetn,
  output logic         o_wire_done,
  output logic         o_wire_error,
  output logic [2:0]   o_wire_error_type,
  input  logic [127:0] i_wire_address,
  input  logic [127:0] i_wire_length,
  input  logic [3:0]   i_wire_router,
  input  logic [127:0] i_wire_data,
  input  logic [3:0]   i_wire_data_valid,
  output logic [3:0]   o_wire_data_next,
  output logic         o_wire_M_AXI_AWID,
  output logic [31:0]  o_wire_M_AXI_AWADDR,
  output logic [7:0]   o_wire_M_AXI_AWLEN,
  output logic [2:0]   o_wire_M_AXI_AWSIZE,
  output logic [1:0]   o_wire_M_AXI_AWBURST,
  output logic         o_wire_M_AXI_AWLOCK,
  output logic [3:0]   o_wire_M_AXI_AWCACHE,
  output logic [2:0]   o_wire_M_AXI_AWPROT,
  output logic [3:0]   o_wire_M_AXI_AWQOS,
  output logic         o_wire_M_AXI_AWVALID,
  input  logic         i_wire_M_AXI_AWREADY,
  output logic [31:0]  o_wire_M_AXI_WDATA,
  output logic [3:0]   o_wire_M_AXI_WSTRB,
  output logic         o_wire_M_AXI_WLAST,
  output logic         o_wire_M_AXI_WVALID,
  input  logic         i_wire_M_AXI_WREADY,
  input  logic         i_wire_M_AXI_BID,
  input  logic [1:0]   i_wire_M_AXI_BRESP,
  input  logic         i_wire_M_AXI_BVALID,
  output logic         o_wire_M_AXI_BREADY
);
  localparam int BW = $clog2(MAX_BURST);
  state_e state_q, state_d;
  err_e etype_q, etype_d;
  logic [1:0] idx_q, idx_d, ridx;
  logic [31:0] addr_q, addr_d, len_q, len_d, off_q, off_d, rem, off_next;
  logic [BW:0] burst_q, burst_d, aligned, burst_calc;
  logic [BW-1:0] beat_q, beat_d, pos;
  logic sel_valid, next_en, wlast, aw_hs, w_hs, b_hs, tmo;
  logic unused_bid;
  assign unused_bid = i_wire_M_AXI_BID;
  painterengine_gpu_dma_source_mux u_mux (
    .i_data  (i_wire_data),
    .i_valid (i_wire_data_valid),
    .i_idx   (idx_q),
    .i_next  (next_en),
    .o_data  (o_wire_M_AXI_WDATA),
    .o_valid (sel_valid),
    .o_next  (o_wire_data_next)
  );
  always_comb begin
    ridx       = router_index(i_wire_router);
    rem        = len_q - off_q;
    pos        = addr_q[BW+1:2] + off_q[BW-1:0];
    aligned    = (BW+1)'(MAX_BURST) - {1'b0, pos};
    burst_calc = (rem < 32'(aligned)) ? rem[BW:0] : aligned;
    off_next   = off_q + 32'(burst_q);
    wlast      = {1'b0, beat_q} == burst_q - (BW+1)'(1);
    aw_hs      = o_wire_M_AXI_AWVALID & i_wire_M_AXI_AWREADY;
    w_hs       = o_wire_M_AXI_WVALID & i_wire_M_AXI_WREADY;
    b_hs       = o_wire_M_AXI_BREADY & i_wire_M_AXI_BVALID;
  end
`ifdef PAINTERENGINE_GPU_WRITER_TIMEOUT_EN
  logic [TIMEOUT_BIT:0] tmo_q, tmo_d;
  always_comb begin
    tmo_d = (state_q inside {ST_ADDR, ST_DATA, ST_RESP}) && !(aw_hs || w_hs || b_hs)
            ? tmo_q + (TIMEOUT_BIT+1)'(1) : '0;
    tmo   = tmo_q[TIMEOUT_BIT];
  end
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn)
    if (!i_wire_resetn) tmo_q <= '0;
    else tmo_q <= tmo_d;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn)
    if (!i_wire_resetn) begin
      state_q <= ST_ROUTING;
      etype_q <= ERR_NONE;
      idx_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      off_q   <= '0;
      burst_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      etype_q <= etype_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      off_q   <= off_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
    end
  always_comb begin
    state_d = state_q;
    etype_d = etype_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    len_d   = len_q;
    off_d   = off_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    case (state_q)
      ST_ROUTING:
        if ($onehot(i_wire_router)) begin
          idx_d   = ridx;
          addr_d  = i_wire_address[{ridx, 5'd0} +: 32];
          len_d   = i_wire_length[{ridx, 5'd0} +: 32];
          state_d = ST_PARAM_CHECK;
        end else begin
          state_d = ST_ERROR;
          etype_d = ERR_ROUTER;
        end
      ST_PARAM_CHECK:
        if (addr_q[1:0] != 2'b00 || len_q == '0) begin
          state_d = ST_ERROR;
          etype_d = ERR_ADDRESS;
        end else state_d = ST_CALC;
      ST_CALC: begin
        burst_d = burst_calc;
        state_d = ST_ADDR;
      end
      ST_ADDR:
        if (tmo) begin
          state_d = ST_ERROR;
          etype_d = ERR_ADDR_TIMEOUT;
        end else if (aw_hs) begin
          beat_d  = '0;
          state_d = ST_DATA;
        end
      ST_DATA:
        if (tmo) begin
          state_d = ST_ERROR;
          etype_d = ERR_DATA_TIMEOUT;
        end else if (w_hs) begin
          beat_d  = beat_q + BW'(1);
          state_d = wlast ? ST_RESP : ST_DATA;
        end
      ST_RESP:
        if (tmo) begin
          state_d = ST_ERROR;
          etype_d = ERR_DATA_TIMEOUT;
        end else if (b_hs) begin
          if (i_wire_M_AXI_BRESP != 2'b00) begin
            state_d = ST_ERROR;
            etype_d = ERR_BRESP;
          end else begin
            off_d   = off_next;
            state_d = (off_next >= len_q) ? ST_DONE : ST_CALC;
          end
        end
      default: ;
    endcase
  end
  always_comb begin
    o_wire_done          = state_q == ST_DONE;
    o_wire_error         = state_q == ST_ERROR;
    o_wire_error_type    = etype_q;
    o_wire_M_AXI_AWID    = 1'b0;
    o_wire_M_AXI_AWADDR  = addr_q + {off_q[29:0], 2'b00};
    o_wire_M_AXI_AWLEN   = 8'(burst_q - (BW+1)'(1));
    o_wire_M_AXI_AWSIZE  = AXI_SIZE_4B;
    o_wire_M_AXI_AWBURST = AXI_BURST_INCR;
    o_wire_M_AXI_AWLOCK  = 1'b0;
    o_wire_M_AXI_AWCACHE = AXI_CACHE_MOD;
    o_wire_M_AXI_AWPROT  = 3'b000;
    o_wire_M_AXI_AWQOS   = 4'h0;
    o_wire_M_AXI_AWVALID = state_q == ST_ADDR;
    o_wire_M_AXI_WSTRB   = 4'hF;
    o_wire_M_AXI_WLAST   = (state_q == ST_DATA) & wlast;
    o_wire_M_AXI_WVALID  = (state_q == ST_DATA) & sel_valid;
    o_wire_M_AXI_BREADY  = state_q == ST_RESP;
    next_en              = i_wire_M_AXI_WREADY & (state_q == ST_DATA);
  end
endmodule

// File: tb/tb_painterengine_gpu_dma_writer.sv
// tb_painterengine_gpu_dma_writer: vector table of jobs against a simple AXI slave and stream-source model.
module tb_painterengine_gpu_dma_writer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic done, error, awid, awlock, awvalid, awready, wlast, wvalid, wready, bid, bvalid, bready;
  logic [2:0] etype, awsize, awprot;
  logic [127:0] address, length, data;
  logic [3:0] router, dvalid, dnext, awcache, awqos, wstrb;
  logic [31:0] awaddr, wdata;
  logic [7:0] awlen;
  logic [1:0] awburst, bresp;
  initial forever #5 clk = ~clk;
  painterengine_gpu_dma_writer #(.TIMEOUT_BIT(6)) dut (
    .i_wire_clock(clk), .i_wire_resetn(rst_n),
    .o_wire_done(done), .o_wire_error(error), .o_wire_error_type(etype),
    .i_wire_address(address), .i_wire_length(length), .i_wire_router(router),
    .i_wire_data(data), .i_wire_data_valid(dvalid), .o_wire_data_next(dnext),
    .o_wire_M_AXI_AWID(awid), .o_wire_M_AXI_AWADDR(awaddr), .o_wire_M_AXI_AWLEN(awlen),
    .o_wire_M_AXI_AWSIZE(awsize), .o_wire_M_AXI_AWBURST(awburst), .o_wire_M_AXI_AWLOCK(awlock),
    .o_wire_M_AXI_AWCACHE(awcache), .o_wire_M_AXI_AWPROT(awprot), .o_wire_M_AXI_AWQOS(awqos),
    .o_wire_M_AXI_AWVALID(awvalid), .i_wire_M_AXI_AWREADY(awready),
    .o_wire_M_AXI_WDATA(wdata), .o_wire_M_AXI_WSTRB(wstrb), .o_wire_M_AXI_WLAST(wlast),
    .o_wire_M_AXI_WVALID(wvalid), .i_wire_M_AXI_WREADY(wready),
    .i_wire_M_AXI_BID(bid), .i_wire_M_AXI_BRESP(bresp), .i_wire_M_AXI_BVALID(bvalid),
    .o_wire_M_AXI_BREADY(bready)
  );
  typedef struct {
    logic [3:0] router; logic [31:0] addr, len; logic [1:0] bresp; int mode;
    logic done, err; logic [2:0] etype; int naw;
    logic [31:0] a0; logic [7:0] l0; logic [31:0] a1; logic [7:0] l1; int pops;
  } vec_t;
  vec_t tbl[$];
  int checks = 0, errors = 0;
  int mode = 0, sel = 0, wcnt, wbeat, nb;
  int pop[4];
  logic [1:0] bresp_first = 2'b00;
  logic [31:0] aw_addrs[$];
  logic [7:0] aw_lens[$], awq[$];
  logic b_pending, b_clear, aw_stall_prev, aw_hs_prev;
  logic [31:0] awaddr_prev;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mk(int s, int k);
    return 32'hA000_0000 | (32'(s) << 20) | 32'(k);
  endfunction
  initial begin
    bid = 1'b0; bresp = 2'b00; bvalid = 1'b0; awready = 1'b0; wready = 1'b0; dvalid = 4'h0; data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0; dvalid = 4'h0;
        wcnt = 0; wbeat = 0; nb = 0; b_pending = 1'b0; b_clear = 1'b0;
        aw_stall_prev = 1'b0; aw_hs_prev = 1'b0; awaddr_prev = '0;
        aw_addrs.delete(); aw_lens.delete(); awq.delete();
        for (int s = 0; s < 4; s++) pop[s] = 0;
      end else begin
        if (b_clear) begin bvalid = 1'b0; b_clear = 1'b0; end
        awready = mode == 1 ? 1'($urandom_range(0, 1)) : mode != 2;
        wready  = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
        dvalid  = {4{mode == 1 ? 1'($urandom_range(0, 1)) : mode != 3}};
        for (int s = 0; s < 4; s++) data[s*32 +: 32] = mk(s, pop[s]);
        if (b_pending && !bvalid && (mode != 1 || $urandom_range(0, 1) == 1)) begin
          bvalid = 1'b1;
          bresp  = nb == 0 ? bresp_first : 2'b00;
        end
        #1;
        if (aw_stall_prev) chk("aw_hold", {awvalid, awaddr}, {1'b1, awaddr_prev});
        if (aw_hs_prev) chk("aw_drop", awvalid, 0);
        aw_stall_prev = awvalid & !awready;
        aw_hs_prev    = awvalid & awready;
        awaddr_prev   = awaddr;
        if (wvalid && wready) begin
          if (awq.size() == 0) chk("w_before_aw", 0, 1);
          else begin
            chk("wdata", wdata, mk(sel, wcnt));
            chk("wlast", wlast, wbeat == int'(awq[0]));
            wcnt++;
            if (wbeat == int'(awq[0])) begin awq.pop_front(); wbeat = 0; b_pending = 1'b1; end
            else wbeat++;
          end
        end
        if (awvalid && awready) begin
          aw_addrs.push_back(awaddr); aw_lens.push_back(awlen); awq.push_back(awlen);
          chk("aw_const", {awid, awsize, awburst, awlock, awcache, awprot, awqos, wstrb},
              {1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'h0, 4'hF});
        end
        if (bvalid && bready) begin b_pending = 1'b0; b_clear = 1'b1; nb++; end
        if ((dnext & ~(4'b0001 << sel)) != 4'h0) chk("next_sel", dnext, dnext & (4'b0001 << sel));
        for (int s = 0; s < 4; s++) if (dnext[s] && dvalid[s]) pop[s]++;
      end
    end
  end
  task automatic setup(input vec_t v, output int slot);
    slot = v.router[1] ? 1 : v.router[2] ? 2 : v.router[3] ? 3 : 0;
    @(negedge clk);
    rst_n = 1'b0;
    mode = v.mode; sel = slot; bresp_first = v.bresp;
    router = v.router; address = '0; length = '0;
    address[slot*32 +: 32] = v.addr;
    length[slot*32 +: 32]  = v.len;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {done, error, etype, awvalid, wvalid, bready, dnext}, 0);
    rst_n = 1'b1;
  endtask
  task automatic run_vec(input vec_t v);
    int slot, cyc, oth;
    setup(v, slot);
    cyc = 0;
    while (!(done || error) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) begin router = 4'hF; address = {4{32'hDEAD_0002}}; length = {4{32'd7}}; end
    end
    chk("job_finished", done | error, 1);
    repeat (4) @(negedge clk);
    #2;
    chk("done", done, v.done);
    chk("error", error, v.err);
    chk("error_type", etype, v.etype);
    chk("aw_count", aw_addrs.size(), v.naw);
    if (v.naw > 0 && aw_addrs.size() > 0) begin
      chk("aw0_addr", aw_addrs[0], v.a0);
      chk("aw0_len", aw_lens[0], v.l0);
    end
    if (v.naw > 1 && aw_addrs.size() > 1) begin
      chk("aw1_addr", aw_addrs[1], v.a1);
      chk("aw1_len", aw_lens[1], v.l1);
    end
    oth = 0;
    for (int s = 0; s < 4; s++) if (s != slot) oth += pop[s];
    chk("pops_selected", pop[slot], v.pops);
    chk("pops_other", oth, 0);
    chk("terminal_idle", {awvalid, wvalid, bready, dnext}, 0);
  endtask
  initial begin
    int slot;
    vec_t mid;
    router = 4'h0; address = '0; length = '0;
    tbl.push_back('{4'h1, 32'h1000, 4,   2'b00, 0, 1, 0, 0, 1, 32'h1000, 3,   0,        0,  4});
    tbl.push_back('{4'h4, 32'h0,    300, 2'b00, 0, 1, 0, 0, 2, 32'h0,    255, 32'h400,  43, 300});
    tbl.push_back('{4'h2, 32'h3C0,  32,  2'b00, 0, 1, 0, 0, 2, 32'h3C0,  15,  32'h400,  15, 32});
    tbl.push_back('{4'h3, 32'h1000, 4,   2'b00, 0, 0, 1, 1, 0, 0,        0,   0,        0,  0});
    tbl.push_back('{4'h0, 32'h1000, 4,   2'b00, 0, 0, 1, 1, 0, 0,        0,   0,        0,  0});
    tbl.push_back('{4'h8, 32'h1002, 4,   2'b00, 0, 0, 1, 2, 0, 0,        0,   0,        0,  0});
    tbl.push_back('{4'h1, 32'h2000, 0,   2'b00, 0, 0, 1, 2, 0, 0,        0,   0,        0,  0});
    tbl.push_back('{4'h2, 32'h0,    300, 2'b10, 0, 0, 1, 5, 1, 32'h0,    255, 0,        0,  256});
    tbl.push_back('{4'h8, 32'h3FC,  1,   2'b00, 0, 1, 0, 0, 1, 32'h3FC,  0,   0,        0,  1});
    tbl.push_back('{4'h4, 32'h3F8,  3,   2'b00, 0, 1, 0, 0, 2, 32'h3F8,  1,   32'h400,  0,  3});
    tbl.push_back('{4'h1, 32'h0,    256, 2'b00, 0, 1, 0, 0, 1, 32'h0,    255, 0,        0,  256});
    tbl.push_back('{4'h4, 32'h0,    300, 2'b00, 1, 1, 0, 0, 2, 32'h0,    255, 32'h400,  43, 300});
    tbl.push_back('{4'h8, 32'h3C0,  32,  2'b00, 1, 1, 0, 0, 2, 32'h3C0,  15,  32'h400,  15, 32});
`ifdef PAINTERENGINE_GPU_WRITER_TIMEOUT_EN
    tbl.push_back('{4'h1, 32'h1000, 4,   2'b00, 2, 0, 1, 3, 0, 0,        0,   0,        0,  0});
    tbl.push_back('{4'h1, 32'h1000, 4,   2'b00, 3, 0, 1, 4, 1, 32'h1000, 3,   0,        0,  0});
`endif
    foreach (tbl[i]) run_vec(tbl[i]);
    mid = tbl[1];
    setup(mid, slot);
    repeat (40) @(negedge clk);
    chk("mid_burst_active", wvalid, 1);
    #2 rst_n = 1'b0;
    #1 chk("mid_burst_reset", {awvalid, wvalid, bready, dnext, done, error}, 0);
    run_vec(tbl[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
